// File: rtl/icw_init_sequencer.sv
// Purpose: 8259-style init/operation command word sequencer. It captures ICW1..ICW4, then OCW1..OCW3, and tracks the init FSM.
// Latency: a command is accepted on the edge that sees write_flag=1 with ACK low. The ACK, the captured word and the new state all appear the next cycle.
// Backpressure: write_flag is held until ACK. No command is accepted in the ACK cycle, so a held flag is taken on alternate cycles.
// Optional feature: define PIC_CMD_ERR_EN to add cmd_err/err_cnt reporting of misplaced commands.
module icw_init_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_flag,
    input  logic       A0,
    input  logic [7:0] data_in,
    output logic       write_flag_ACK,
    output logic [7:0] ICW1,
    output logic [7:0] ICW2,
    output logic [7:0] ICW3,
    output logic [7:0] ICW4,
    output logic [7:0] OCW1,
    output logic [7:0] OCW2,
    output logic [7:0] OCW3,
    output logic       ocw2_strobe,
    output logic       init_done,
    output logic [2:0] state
`ifdef PIC_CMD_ERR_EN
    ,
    output logic       cmd_err,
    output logic [3:0] err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_ack;
    logic [7:0] r_icw1, r_icw2, r_icw3, r_icw4;
    logic [7:0] r_ocw1, r_ocw2, r_ocw3;
    logic       r_ocw2_strobe;
    logic       r_init_done;

    logic       w_accept;
    logic       w_is_icw1;
    logic       w_cap_icw1, w_cap_icw2, w_cap_icw3, w_cap_icw4;
    logic       w_cap_ocw1, w_cap_ocw2, w_cap_ocw3;

    // A command is taken only outside the ACK cycle. ICW1 is recognised in every state.
    assign w_accept  = write_flag & ~r_ack;
    assign w_is_icw1 = ~A0 & data_in[4];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode and capture selects. A misplaced command selects nothing.
    always_comb begin
        w_next_state = r_state;
        w_cap_icw1   = 1'b0;
        w_cap_icw2   = 1'b0;
        w_cap_icw3   = 1'b0;
        w_cap_icw4   = 1'b0;
        w_cap_ocw1   = 1'b0;
        w_cap_ocw2   = 1'b0;
        w_cap_ocw3   = 1'b0;
        if (w_accept) begin
            if (w_is_icw1) begin
                w_cap_icw1   = 1'b1;
                w_next_state = WAIT_ICW2;
            end else begin
                case (r_state)
                    WAIT_ICW2: if (A0) begin
                        w_cap_icw2 = 1'b1;
                        // ICW1[1]=0 means cascaded, so ICW3 follows. ICW1[0] requests ICW4.
                        if (!r_icw1[1])     w_next_state = WAIT_ICW3;
                        else if (r_icw1[0]) w_next_state = WAIT_ICW4;
                        else                w_next_state = READY;
                    end
                    WAIT_ICW3: if (A0) begin
                        w_cap_icw3   = 1'b1;
                        w_next_state = r_icw1[0] ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (A0) begin
                        w_cap_icw4   = 1'b1;
                        w_next_state = READY;
                    end
                    READY: begin
                        if (A0)               w_cap_ocw1 = 1'b1;
                        else if (data_in[3])  w_cap_ocw3 = 1'b1;
                        else                  w_cap_ocw2 = 1'b1;
                    end
                    default: w_next_state = r_state;
                endcase
            end
        end
    end

    // Command word registers, ACK/strobe pulses and the init_done flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack         <= 1'b0;
            r_icw1        <= 8'h00;
            r_icw2        <= 8'h00;
            r_icw3        <= 8'h00;
            r_icw4        <= 8'h00;
            r_ocw1        <= 8'h00;
            r_ocw2        <= 8'h00;
            r_ocw3        <= 8'h00;
            r_ocw2_strobe <= 1'b0;
            r_init_done   <= 1'b0;
        end else begin
            r_ack         <= w_accept;
            r_ocw2_strobe <= w_cap_ocw2;
            r_init_done   <= (w_next_state == READY);
            if (w_cap_icw1) begin
                r_icw1 <= data_in;
                // A fresh init drops any stale ICW4/mask. ICW2/ICW3 stay until rewritten.
                r_icw4 <= 8'h00;
                r_ocw1 <= 8'h00;
            end
            if (w_cap_icw2) r_icw2 <= data_in;
            if (w_cap_icw3) r_icw3 <= data_in;
            if (w_cap_icw4) r_icw4 <= data_in;
            if (w_cap_ocw1) r_ocw1 <= data_in;
            if (w_cap_ocw2) r_ocw2 <= data_in;
            if (w_cap_ocw3) r_ocw3 <= data_in;
        end
    end

`ifdef PIC_CMD_ERR_EN
    logic       w_bad;
    logic       r_cmd_err;
    logic [3:0] r_err_cnt;

    assign w_bad = w_accept & ((A0 & (r_state == IDLE)) |
                               (~A0 & ~data_in[4] & (r_state != READY)));

    // Error pulse aligned with the ACK. The counter saturates and is cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_err <= 1'b0;
            r_err_cnt <= 4'd0;
        end else begin
            r_cmd_err <= w_bad;
            if (w_bad && r_err_cnt != 4'hF) r_err_cnt <= r_err_cnt + 4'd1;
        end
    end

    assign cmd_err = r_cmd_err;
    assign err_cnt = r_err_cnt;
`endif

    assign write_flag_ACK = r_ack;
    assign ICW1           = r_icw1;
    assign ICW2           = r_icw2;
    assign ICW3           = r_icw3;
    assign ICW4           = r_icw4;
    assign OCW1           = r_ocw1;
    assign OCW2           = r_ocw2;
    assign OCW3           = r_ocw3;
    assign ocw2_strobe    = r_ocw2_strobe;
    assign init_done      = r_init_done;
    assign state          = r_state;

endmodule

// File: tb/tb_icw_init_sequencer.sv
// Bench for icw_init_sequencer: directed init/operation scenarios plus randomized traffic.
// Every cycle is checked against a command-level reference model of the sequencer.
// The error-reporting outputs are checked as well when PIC_CMD_ERR_EN is defined.
module tb_icw_init_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_flag;
    logic       A0;
    logic [7:0] data_in;
    logic       write_flag_ACK;
    logic [7:0] ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3;
    logic       ocw2_strobe;
    logic       init_done;
    logic [2:0] state;
`ifdef PIC_CMD_ERR_EN
    logic       cmd_err;
    logic [3:0] err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: command words kept in an array, index 1..4 = ICW, 5..7 = OCW1..3
    int         m_state;
    logic [7:0] m_word [1:7];
    logic       m_ack, m_strobe, m_init, m_err;
    int         m_cnt;

    icw_init_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .write_flag    (write_flag),
        .A0            (A0),
        .data_in       (data_in),
        .write_flag_ACK(write_flag_ACK),
        .ICW1          (ICW1),
        .ICW2          (ICW2),
        .ICW3          (ICW3),
        .ICW4          (ICW4),
        .OCW1          (OCW1),
        .OCW2          (OCW2),
        .OCW3          (OCW3),
        .ocw2_strobe   (ocw2_strobe),
        .init_done     (init_done),
        .state         (state)
`ifdef PIC_CMD_ERR_EN
        ,
        .cmd_err       (cmd_err),
        .err_cnt       (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        for (int i = 1; i <= 7; i++) m_word[i] = 8'h00;
        m_ack    = 1'b0;
        m_strobe = 1'b0;
        m_init   = 1'b0;
        m_err    = 1'b0;
        m_cnt    = 0;
    endtask

    // One clock edge of the command protocol, applied with the inputs seen at that edge
    task automatic model_edge(input logic wf, input logic a0, input logic [7:0] d);
        logic acc;
        logic bad;
        acc      = wf && !m_ack;
        bad      = 1'b0;
        m_ack    = acc;
        m_strobe = 1'b0;
        if (acc) begin
            if (!a0 && d[4]) begin
                m_word[1] = d; m_word[4] = 8'h00; m_word[5] = 8'h00; m_state = 1;
            end else if (m_state == 4) begin
                if (a0)        m_word[5] = d;
                else if (d[3]) m_word[7] = d;
                else begin     m_word[6] = d; m_strobe = 1'b1; end
            end else if (!a0 || m_state == 0) begin
                bad = 1'b1;
            end else begin
                m_word[m_state + 1] = d;
                if (m_state == 1 && !m_word[1][1]) m_state = 2;
                else if (m_state < 3 && m_word[1][0]) m_state = 3;
                else m_state = 4;
            end
        end
        m_err  = bad;
        if (bad && m_cnt < 15) m_cnt++;
        m_init = (m_state == 4);
    endtask

    task automatic compare_all();
        chk("state", {5'd0, state}, 8'(m_state));
        chk("ack", {7'd0, write_flag_ACK}, {7'd0, m_ack});
        chk("icw1", ICW1, m_word[1]);
        chk("icw2", ICW2, m_word[2]);
        chk("icw3", ICW3, m_word[3]);
        chk("icw4", ICW4, m_word[4]);
        chk("ocw1", OCW1, m_word[5]);
        chk("ocw2", OCW2, m_word[6]);
        chk("ocw3", OCW3, m_word[7]);
        chk("strobe", {7'd0, ocw2_strobe}, {7'd0, m_strobe});
        chk("init_done", {7'd0, init_done}, {7'd0, m_init});
`ifdef PIC_CMD_ERR_EN
        chk("cmd_err", {7'd0, cmd_err}, {7'd0, m_err});
        chk("err_cnt", {4'd0, err_cnt}, 8'(m_cnt));
`endif
    endtask

    task automatic step(input logic wf, input logic a0, input logic [7:0] d);
        write_flag = wf;
        A0         = a0;
        data_in    = d;
        @(posedge clk);
        model_edge(wf, a0, d);
        #1;
        compare_all();
    endtask

    // A single command: raise write_flag for the accept edge, then drop it for the ACK cycle
    task automatic wr(input logic a0, input logic [7:0] d);
        step(1'b1, a0, d);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int acks;
        logic       wf, a0;
        logic [7:0] d;

        reset = 1'b1; write_flag = 1'b0; A0 = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();

        // Flag already high at reset release: accepted on the first edge
        write_flag = 1'b1; A0 = 1'b0; data_in = 8'h11;
        #1 reset = 1'b0;
        step(1'b1, 1'b0, 8'h11);
        chk("rel_accept_ack", {7'd0, write_flag_ACK}, 8'h01);
        step(1'b0, 1'b0, 8'h00);

        // Full sequence with ICW3 and ICW4
        wr(1'b1, 8'h17); chk("seq_s2", {5'd0, state}, 8'd2);
        wr(1'b1, 8'h55); chk("seq_s3", {5'd0, state}, 8'd3);
        wr(1'b1, 8'h8F); chk("seq_s4", {5'd0, state}, 8'd4);
        chk("seq_icw4", ICW4, 8'h8F);
        chk("seq_done", {7'd0, init_done}, 8'h01);

        // Operation words in READY
        wr(1'b1, 8'hFB); chk("ocw1_val", OCW1, 8'hFB);
        step(1'b1, 1'b0, 8'h20); chk("ocw2_pulse", {7'd0, ocw2_strobe}, 8'h01);
        step(1'b0, 1'b0, 8'h00); chk("ocw2_once", {7'd0, ocw2_strobe}, 8'h00);
        wr(1'b0, 8'h0B); chk("ocw3_val", OCW3, 8'h0B);

        // Single, no ICW4: straight to READY with ICW4 cleared
        wr(1'b0, 8'h12); chk("skip_s1", {5'd0, state}, 8'd1);
        wr(1'b1, 8'h20); chk("skip_ready", {5'd0, state}, 8'd4);
        chk("skip_icw4", ICW4, 8'h00);

        // ICW1 mid-sequence restarts and keeps ICW2
        wr(1'b0, 8'h11); wr(1'b1, 8'h17); wr(1'b0, 8'h13);
        chk("restart_state", {5'd0, state}, 8'd1);
        chk("restart_icw2", ICW2, 8'h17);
        chk("restart_done", {7'd0, init_done}, 8'h00);

        // Held flag: six cycles give three ACKs on alternate cycles
        wr(1'b1, 8'h17); wr(1'b1, 8'h44);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 8'(8'hA0 + i));
            if (write_flag_ACK) acks++;
        end
        chk("held_acks", 8'(acks), 8'd3);
        step(1'b0, 1'b0, 8'h00);

        // Reset mid-sequence
        step(1'b1, 1'b0, 8'h11);
        async_reset();
        chk("rst_state", {5'd0, state}, 8'd0);
        chk("rst_icw1", ICW1, 8'h00);

`ifdef PIC_CMD_ERR_EN
        for (int i = 0; i < 17; i++) wr(1'b1, 8'(i));
        chk("err_sat", {4'd0, err_cnt}, 8'd15);
        chk("err_idle", {5'd0, state}, 8'd0);
`endif

        // Randomized traffic, with an occasional asynchronous reset
        for (int i = 0; i < 3000; i++) begin
            wf = ($urandom_range(0, 3) != 0);
            a0 = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (!a0 && $urandom_range(0, 3) != 0) d[4] = 1'b0;
            step(wf, a0, d);
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
